pipelined_addsub: RTL and testbench

- Parametrised, pipelined N-bit adder/subtractor, successor to the combinational N-bit adder.
- Splits the carry chain into STAGES chunk-wide registered segments so wide adds close timing.
- Adds subtract mode, carry/overflow/zero flags and a valid/ready handshake with backpressure.
- Sits between an operand source (e.g. a multi-cycle ALU sequencer) and a result consumer.

---
 rtl/pipelined_addsub.sv | 130 +++++++++++++
 tb/tb_pipelined_addsub.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined N-bit adder/subtractor. The carry chain is cut into STAGES chunk-wide
// registered segments, and the whole pipe advances only when the output slot frees up.
module pipelined_addsub #(
  parameter int N      = 32,
  parameter int STAGES = 4   // N must be a multiple of STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int W = N / STAGES;

  logic en;
  logic ovf_q;
  logic zero_q;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // Operands entering stage gi hold only the chunks not yet consumed; bit 0 is chunk gi.
      logic [N-gi*W-1:0]   a_in;
      logic [N-gi*W-1:0]   b_in;
      logic                cin;
      logic                valid_in;
      logic                sub_in;
      logic [W-1:0]        a_chunk;
      logic [W-1:0]        b_chunk;
      logic [W:0]          ext;
      logic [(gi+1)*W-1:0] res_d;
      logic [(gi+1)*W-1:0] res_q;
      logic                carry_q;
      logic                valid_q;

      if (gi == 0) begin : g_head
        assign a_in     = a;
        assign b_in     = b;
        assign cin      = sub;
        assign valid_in = in_valid;
        assign sub_in   = sub;
        assign res_d    = ext[W-1:0];
      end else begin : g_link
        assign a_in     = g_stage[gi-1].g_fwd.a_q;
        assign b_in     = g_stage[gi-1].g_fwd.b_q;
        assign cin      = g_stage[gi-1].carry_q;
        assign valid_in = g_stage[gi-1].valid_q;
        assign sub_in   = g_stage[gi-1].g_fwd.sub_q;
        assign res_d    = {ext[W-1:0], g_stage[gi-1].res_q};
      end

      // Subtract is A + ~B + 1: each stage inverts its own chunk, stage 0 injects the +1.
      assign a_chunk = a_in[W-1:0];
      assign b_chunk = b_in[W-1:0] ^ {W{sub_in}};
      assign ext     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{W{1'b0}}, cin};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          carry_q <= 1'b0;
          res_q   <= '0;
        end else begin
          if (flush) begin
            valid_q <= 1'b0;
          end else if (en) begin
            valid_q <= valid_in;
          end
          if (en) begin
            carry_q <= ext[W];
            res_q   <= res_d;
          end
        end
      end

      if (gi < STAGES - 1) begin : g_fwd
        logic [N-(gi+1)*W-1:0] a_q;
        logic [N-(gi+1)*W-1:0] b_q;
        logic                  sub_q;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
          end else if (en) begin
            a_q   <= a_in[N-gi*W-1:W];
            b_q   <= b_in[N-gi*W-1:W];
            sub_q <= sub_in;
          end
        end
      end

      if (gi == STAGES - 1) begin : g_tail
        // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
        logic msb_cin;
        assign msb_cin = ext[W-1] ^ a_chunk[W-1] ^ b_chunk[W-1];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
          end else if (en) begin
            ovf_q  <= msb_cin ^ ext[W];
            zero_q <= (res_d == '0);
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].res_q;
  assign cout      = g_stage[STAGES-1].carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed corner cases, backpressure, flush, async reset,
// then randomized traffic scored against an arithmetic reference queue.
module tb_pipelined_addsub;

  localparam int N      = 32;
  localparam int STAGES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  always #5 clk = ~clk;

  pipelined_addsub #(.N(N), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  res_t exp_q[$];
  res_t exp_e;
  int   checks = 0;
  int   errors = 0;
  int   rx = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the operands.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    res_t        r;
    logic [32:0] t;
    if (!s) begin
      t   = {1'b0, x} + {1'b0, y};
      r.s = t[31:0];
      r.c = t[32];
      r.v = (x[31] == y[31]) && (r.s[31] != x[31]);
    end else begin
      r.s = x - y;
      r.c = (x >= y);
      r.v = (x[31] != y[31]) && (r.s[31] != x[31]);
    end
    r.z = (r.s == 32'h0);
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: results popped in acceptance order; held outputs checked across stalls.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_sum = '0;
  logic [2:0]  prev_flags = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {63'b0, out_valid}, 64'd1);
        chk("hold_sum", {32'b0, sum}, {32'b0, prev_sum});
        chk("hold_flags", {61'b0, cout, ovf, zero}, {61'b0, prev_flags});
      end
      if (out_valid && !out_ready) chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", {63'b0, out_valid}, 64'd0);
        end else begin
          exp_e = exp_q.pop_front();
          $display("rx %0d sum=%08h cout=%b ovf=%b zero=%b", rx, sum, cout, ovf, zero);
          chk("sum", {32'b0, sum}, {32'b0, exp_e.s});
          chk("cout", {63'b0, cout}, {63'b0, exp_e.c});
          chk("ovf", {63'b0, ovf}, {63'b0, exp_e.v});
          chk("zero", {63'b0, zero}, {63'b0, exp_e.z});
          rx++;
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(a, b, sub));
      prev_stall = out_valid && !out_ready && !flush;
      prev_sum   = sum;
      prev_flags = {cout, ovf, zero};
    end
  end

  // Issue one beat into an idle pipe, measure latency, and check the spec-given result.
  task automatic timed_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic [31:0] exp_sum, input logic [2:0] exp_cvz,
                          input string tag);
    int lat;
    a = x; b = y; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_sum"}, {32'b0, sum}, {32'b0, exp_sum});
    chk({tag, "_cout_ovf_zero"}, {61'b0, cout, ovf, zero}, {61'b0, exp_cvz});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rx0;
    int   sent;
    logic acc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_sum", {32'b0, sum}, 64'd0);
    chk("reset_flags", {61'b0, cout, ovf, zero}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Directed vectors, expected values straight from the arithmetic
    timed_op(32'h0000_00FF, 32'h1, 1'b0, 32'h0000_0100, 3'b000, "basic_add");
    @(posedge clk); #1;
    timed_op(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0000_0000, 3'b101, "ripple");
    @(posedge clk); #1;
    timed_op(32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 3'b010, "pos_ovf");
    @(posedge clk); #1;
    timed_op(32'h5, 32'h5, 1'b1, 32'h0000_0000, 3'b101, "sub_eq");
    @(posedge clk); #1;
    timed_op(32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 3'b110, "sub_ovf");
    @(posedge clk); #1;
    timed_op(32'h0, 32'h1, 1'b1, 32'hFFFF_FFFF, 3'b000, "sub_borrow");
    @(posedge clk); #1;

    // Backpressure: 8 back-to-back adds, consumer stalls for cycles 6..8
    rx0  = rx;
    sent = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      if (sent < 8) begin
        in_valid = 1'b1;
        a        = 32'(sent);
        b        = 32'h10 * 32'(sent);
        sub      = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (cyc >= 6 && cyc <= 8) chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_delivered", 64'(rx - rx0), 64'd8);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Flush: three beats in flight, then one flush cycle with a beat that must be discarded
    rx0 = rx;
    for (int i = 0; i < 3; i++) begin
      a = 32'h100 + 32'(i); b = 32'h1; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    a = 32'hDEAD; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
      @(posedge clk); #1;
    end
    chk("flush_nothing_out", 64'(rx - rx0), 64'd0);
    timed_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 3'b000, "post_flush");
    @(posedge clk); #1;

    // Asynchronous reset between clock edges while results are flowing
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 32'h1000 * 32'(i + 1); b = 32'h3; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("pre_reset_out_valid", {63'b0, out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_out_valid", {63'b0, out_valid}, 64'd0);
    chk("async_sum", {32'b0, sum}, 64'd0);
    chk("async_flags", {61'b0, cout, ovf, zero}, 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    timed_op(32'h0000_0040, 32'h0000_0002, 1'b0, 32'h0000_0042, 3'b000, "post_reset");
    @(posedge clk); #1;

    // Randomized traffic with random stalls and occasional flushes
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 50) == 0;
      a         = pick();
      b         = pick();
      sub       = 1'($urandom % 2);
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_out_valid", {63'b0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
